// File: rtl/decay_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decay_scheduler                                            |
// | Description : Shares one decay-multiplier lookup across NVOICE voices,   |
// |               keeping per-voice ages and a global decay time base.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module decay_scheduler #(
    parameter int NVOICE   = 4,
    parameter int TICK_DIV = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NVOICE-1:0]   key_on,
    input  logic [NVOICE-1:0]   key_off,
    output logic [5:0]          lut_curr,
    output logic [5:0]          lut_start,
    input  logic [7:0]          lut_multiple,
    output logic [8*NVOICE-1:0] gain_out,
    output logic                gain_valid,
    output logic [NVOICE-1:0]   active,
    output logic                busy
);

    localparam int                 c_SEL_W     = $clog2(NVOICE);
    localparam int                 c_CNT_W     = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_LAST  = c_SEL_W'(NVOICE - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [c_CNT_W-1:0]  r_tick_cnt;
    logic [5:0]          r_tb;
    logic [5:0]          r_age [NVOICE];
    logic [NVOICE-1:0]   r_active;
    logic                r_pending;
    logic [1:0]          r_state;
    logic [c_SEL_W-1:0]  r_sel;
    logic [8*NVOICE-1:0] r_gain;

    logic w_tick;
    logic w_trigger;
    logic w_launch;

    assign w_tick    = (r_tick_cnt == c_TICK_LAST);
    assign w_trigger = (|key_on) | (|key_off) | w_tick;
    // A pending request is consumed whenever the FSM is free to start a scan.
    assign w_launch  = r_pending & (r_state != c_SCAN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_tb       <= 6'd0;
            r_active   <= '0;
            for (int v = 0; v < NVOICE; v++) begin
                r_age[v] <= 6'd0;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_tb <= r_tb - 6'd1;
            end
            // key_on overrides both key_off and the tick for the same voice.
            for (int v = 0; v < NVOICE; v++) begin
                if (key_on[v]) begin
                    r_age[v]    <= 6'd0;
                    r_active[v] <= 1'b1;
                end else begin
                    if (w_tick && r_active[v] && (r_age[v] != 6'd63)) begin
                        r_age[v] <= r_age[v] + 6'd1;
                    end
                    if (key_off[v] || (w_tick && r_active[v] && (r_age[v] == 6'd63))) begin
                        r_active[v] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_sel     <= '0;
            r_pending <= 1'b0;
            r_gain    <= '0;
        end else begin
            r_pending <= w_trigger | (r_pending & ~w_launch);
            case (r_state)
                c_IDLE: begin
                    if (r_pending) begin
                        r_state <= c_SCAN;
                        r_sel   <= '0;
                    end
                end
                c_SCAN: begin
                    r_gain[{r_sel, 3'b000} +: 8] <= r_active[r_sel] ? lut_multiple : 8'h00;
                    if (r_sel == c_SEL_LAST) begin
                        r_state <= c_DONE;
                        r_sel   <= '0;
                    end else begin
                        r_sel <= r_sel + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= r_pending ? c_SCAN : c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // The lookup index (start - curr) equals the selected voice's age.
    assign lut_curr   = r_tb;
    assign lut_start  = r_tb + r_age[r_sel];
    assign gain_out   = r_gain;
    assign gain_valid = (r_state == c_DONE);
    assign busy       = (r_state == c_SCAN) || (r_state == c_DONE);
    assign active     = r_active;

endmodule
`default_nettype wire

// File: tb/tb_decay_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decay_scheduler                                         |
// | Description : Self-checking bench for decay_scheduler with a reference   |
// |               model of voices, time base and scan schedule.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_decay_scheduler;

    localparam int NV = 4;
    localparam int TD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NV-1:0] key_on = '0;
    logic [NV-1:0] key_off = '0;
    logic [5:0]    lut_curr;
    logic [5:0]    lut_start;
    logic [7:0]    lut_multiple;
    logic [8*NV-1:0] gain_out;
    logic          gain_valid;
    logic [NV-1:0] active;
    logic          busy;

    logic [7:0] lut_tab [64];
    logic [5:0] lut_idx;

    assign lut_idx      = lut_start - lut_curr;
    assign lut_multiple = lut_tab[lut_idx];

    always #5 clk = ~clk;

    decay_scheduler #(
        .NVOICE   (NV),
        .TICK_DIV (TD)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .key_on       (key_on),
        .key_off      (key_off),
        .lut_curr     (lut_curr),
        .lut_start    (lut_start),
        .lut_multiple (lut_multiple),
        .gain_out     (gain_out),
        .gain_valid   (gain_valid),
        .active       (active),
        .busy         (busy)
    );

    // Reference model: edge count since reset release, voice state, scan schedule.
    int n;
    int m_age [NV];
    bit m_act [NV];
    int m_tb;
    bit m_pend;
    int m_last;
    int snap_age [8192][NV];
    bit snap_act [8192][NV];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired, got no event expected event (edge %0d)", tag, n);
    endtask

    task automatic model_reset();
        n      = 0;
        m_tb   = 0;
        m_pend = 1'b0;
        m_last = -1000;
        for (int v = 0; v < NV; v++) begin
            m_age[v] = 0;
            m_act[v] = 1'b0;
            snap_age[0][v] = 0;
            snap_act[0][v] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [NV-1:0] on, input logic [NV-1:0] off);
        bit tick;
        bit trig;
        n++;
        tick = ((n % TD) == 0);
        trig = (on != 0) || (off != 0) || tick;
        for (int v = 0; v < NV; v++) begin
            if (on[v]) begin
                m_age[v] = 0;
                m_act[v] = 1'b1;
            end else begin
                bool_release: begin
                    bit was_act;
                    int old_age;
                    was_act = m_act[v];
                    old_age = m_age[v];
                    if (tick && was_act && old_age < 63) m_age[v] = old_age + 1;
                    if (off[v] || (tick && was_act && old_age == 63)) m_act[v] = 1'b0;
                end
            end
            snap_age[n & 8191][v] = m_age[v];
            snap_act[n & 8191][v] = m_act[v];
        end
        if (tick) m_tb = (m_tb + 63) % 64;
        // A scan may start once the previous one (N capture cycles + done) is over.
        if (m_pend && n >= m_last + NV + 1) begin
            m_last = n;
            m_pend = 1'b0;
        end
        if (trig) m_pend = 1'b1;
    endtask

    task automatic check_all();
        logic [NV-1:0]   exp_act;
        logic [8*NV-1:0] exp_gain;
        bit              exp_busy;
        bit              exp_valid;
        int              idx;
        for (int v = 0; v < NV; v++) exp_act[v] = m_act[v];
        exp_busy  = (n >= m_last) && (n <= m_last + NV);
        exp_valid = (n == m_last + NV);
        check_eq("active", active, exp_act);
        check_eq("lut_curr", lut_curr, m_tb);
        check_eq("busy", busy, exp_busy);
        check_eq("gain_valid", gain_valid, exp_valid);
        if (!exp_busy) check_eq("lut_start_idle", lut_start, (m_tb + m_age[0]) % 64);
        if (exp_valid) begin
            for (int v = 0; v < NV; v++) begin
                idx = (n - NV + v) & 8191;
                exp_gain[8*v +: 8] = snap_act[idx][v] ? lut_tab[snap_age[idx][v]] : 8'h00;
            end
            check_eq("gain_out", gain_out, exp_gain);
        end
    endtask

    task automatic step(input logic [NV-1:0] on, input logic [NV-1:0] off);
        key_on  = on;
        key_off = off;
        @(posedge clk);
        model_edge(on, off);
        @(negedge clk);
        key_on  = '0;
        key_off = '0;
        check_all();
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            step('0, '0);
            if (gain_valid === 1'b1) at = n;
        end
        if (at < 0) timeout_fail("wait_valid");
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step('0, '0);
            if (busy === 1'b1) seen = 1'b1;
        end
        if (!seen) timeout_fail("wait_busy");
    endtask

    initial begin
        int t0;
        int t1;
        logic [NV-1:0] ron;
        logic [NV-1:0] roff;

        for (int i = 0; i < 64; i++) begin
            lut_tab[i] = 8'($rtoi(128.0 * (2.0 ** (-real'(i) / 33.0))));
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_gain", gain_out, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", gain_valid, 0);
        check_eq("rst_lut_curr", lut_curr, 0);
        check_eq("rst_lut_start", lut_start, 0);
        rst = 1'b1;

        // Idle: only tick scans, time base counting down.
        repeat (100) step('0, '0);

        for (int i = 0; i < TD && (n % TD) != 7; i++) step('0, '0);
        step(4'b0001, '0);
        t0 = n;
        check_eq("keyon0_active", active, 4'b0001);
        wait_valid(t1);
        check_eq("keyon0_latency", t1 - t0, NV + 1);
        check_eq("keyon0_gain0", gain_out[7:0], 8'h80);
        check_eq("keyon0_others", gain_out[8*NV-1:8], 0);
        wait_valid(t1);
        check_eq("tick1_gain0", gain_out[7:0], 8'h7D);
        repeat (9) wait_valid(t1);
        check_eq("tick10_gain0", gain_out[7:0], 8'h67);
        repeat (53) wait_valid(t1);
        check_eq("tick63_gain0", gain_out[7:0], 8'h22);
        check_eq("tick63_active0", active[0], 1'b1);
        wait_valid(t1);
        check_eq("tick64_active0", active[0], 1'b0);
        check_eq("tick64_gain0", gain_out[7:0], 8'h00);

        // key_on during a tick scan forces an immediate back-to-back rescan.
        wait_busy();
        step(4'b0100, '0);
        wait_valid(t0);
        wait_valid(t1);
        check_eq("rescan_spacing", t1 - t0, NV + 1);
        check_eq("rescan_gain2", gain_out[23:16], 8'h80);

        step(4'b0010, 4'b0010);
        check_eq("on_off_active1", active[1], 1'b1);
        wait_valid(t1);
        check_eq("on_off_gain1", gain_out[15:8], 8'h80);

        for (int i = 0; i < 1000 && m_age[1] != 20; i++) step('0, '0);
        wait_valid(t1);
        check_eq("age20_gain1", gain_out[15:8], 8'h54);
        step(4'b0010, '0);
        wait_valid(t1);
        check_eq("retrig_gain1", gain_out[15:8], 8'h80);
        step('0, 4'b0010);
        wait_valid(t1);
        check_eq("keyoff_gain1", gain_out[15:8], 8'h00);

        // Asynchronous reset in the middle of a scan.
        step(4'b0101, '0);
        wait_busy();
        rst = 1'b0;
        #1;
        check_eq("midrst_gain", gain_out, 0);
        check_eq("midrst_active", active, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", gain_valid, 0);
        check_eq("midrst_lut_curr", lut_curr, 0);
        check_eq("midrst_lut_start", lut_start, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        wait_valid(t1);
        check_eq("first_valid_after_rst", t1, TD + NV + 1);

        // Random key traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            ron  = ($urandom_range(0, 9) == 0)  ? NV'($urandom_range(0, 15)) : '0;
            roff = ($urandom_range(0, 11) == 0) ? NV'($urandom_range(0, 15)) : '0;
            step(ron, roff);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
